// File: rtl/screen_mem_arbiter_pkg.sv
// Shared constants and payload types for the Hack data-memory / screen scan-out arbiter.
package screen_mem_arbiter_pkg;

    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned SCREEN_WORDS = 8192;
    localparam int unsigned FETCH_W      = $clog2(SCREEN_WORDS);

    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;

    // One FIFO entry: 16 pixels plus the start-of-frame marker.
    typedef struct packed {
        logic              sof;
        logic [DATA_W-1:0] data;
    } pix_word_t;

    // Screen word index -> absolute data-memory address.
    function automatic logic [ADDR_W-1:0] screen_addr(input logic [FETCH_W-1:0] idx);
        return SCREEN_BASE | ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/screen_mem_arbiter_pixel_fifo.sv
// Small synchronous FIFO holding fetched screen words; head is shown combinationally.
module screen_mem_arbiter_pixel_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Overflow and underflow requests are dropped rather than corrupting state.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; only the pointers qualify it.
    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/screen_mem_arbiter.sv
// Arbitrates the single-port Hack data memory between the CPU and the screen scan-out engine.
module screen_mem_arbiter
    import screen_mem_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOW_WATER  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_enable,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_valid,
    input  logic              pix_ready,
    input  logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]   count;
    logic [FETCH_W-1:0] fetch_addr;
    logic               space;
    logic               urgent;
    logic               vfetch;
    logic               cgrant;
    logic               pop;
    pix_word_t          push_word;
    pix_word_t          head_word;

    // Video only preempts the CPU once the FIFO is nearly drained.
    assign space  = count < CNT_W'(FIFO_DEPTH);
    assign urgent = count < CNT_W'(LOW_WATER);
    assign vfetch = !reset && vid_enable && space && (urgent || !cpu_req);
    assign cgrant = !reset && cpu_req && !vfetch;

    assign pix_valid = (count != '0);
    assign pop       = pix_valid && pix_ready;

    assign push_word.sof  = (fetch_addr == '0);
    assign push_word.data = mem_out;

    // Fetch counter wraps naturally at the end of the screen; disable restarts at word 0.
    always_ff @(posedge clock) begin
        if (reset || !vid_enable) begin
            fetch_addr <= '0;
        end else if (vfetch) begin
            fetch_addr <= fetch_addr + FETCH_W'(1);
        end
    end

    screen_mem_arbiter_pixel_fifo #(
        .WIDTH ($bits(pix_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clock (clock),
        .reset (reset),
        .flush (!vid_enable),
        .push  (vfetch),
        .pop   (pop),
        .din   (push_word),
        .head  (head_word),
        .count (count)
    );

    assign pix_data = head_word.data;
    assign pix_sof  = head_word.sof;

    // Memory port mux; idle cycles drive zeros so nothing stray reaches memory.
    always_comb begin
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        cpu_ack     = 1'b0;
        cpu_rdata   = '0;
        if (cgrant) begin
            mem_address = cpu_addr;
            mem_in      = cpu_wdata;
            mem_load    = cpu_we;
            cpu_ack     = 1'b1;
            cpu_rdata   = mem_out;
        end else if (vfetch) begin
            mem_address = screen_addr(fetch_addr);
        end
    end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed self-checking bench for screen_mem_arbiter with a behavioural Hack data memory.
module tb_screen_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_enable;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] mem_out;
    logic [14:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram [32768];
    bit          loaded = 1'b0;

    always #5 clock = ~clock;

    screen_mem_arbiter #(.FIFO_DEPTH(4), .LOW_WATER(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .vid_enable  (vid_enable),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .mem_out     (mem_out),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load)
    );

    // Memory: preload on the first edge, asynchronous read, keyboard-range writes dropped.
    assign mem_out = ram[mem_address];
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) begin
                if (i >= 16'h4000 && i < 16'h6000) ram[i] <= 16'(16'hA000 + (i - 16'h4000));
                else if (i == 16'h0010)          ram[i] <= 16'h1234;
                else if (i == 16'h0200)          ram[i] <= 16'h7777;
                else                             ram[i] <= 16'h0000;
            end
            loaded <= 1'b1;
        end else if (mem_load && mem_address < 15'h6000) begin
            ram[mem_address] <= mem_in;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; vid_enable = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; pix_ready = 1'b0;
        #2;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", cpu_ack); end
        checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL rst_load: got %b want 0", mem_load); end
        checks++; if (mem_address !== 15'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", mem_address); end
        step();
        step();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pix_valid); end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [14:0] exp_a;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_a = 15'(15'h4000 + k);
            checks++; if (mem_address !== exp_a) begin errors++; $display("FAIL fill_addr %0d: got %h want %h", k, mem_address, exp_a); end
            checks++; if (mem_load !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL fill_ctl %0d: got load=%b ack=%b want 0 0", k, mem_load, cpu_ack); end
            checks++; if (pix_valid !== (k != 0)) begin errors++; $display("FAIL fill_valid %0d: got %b want %b", k, pix_valid, (k != 0)); end
            step();
        end
        #1;
        checks++; if (mem_address !== 15'h0000) begin errors++; $display("FAIL fill_idle: got %h want 0000", mem_address); end
        checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000 || pix_sof !== 1'b1)
            begin errors++; $display("FAIL fill_head: got v=%b d=%h s=%b want 1 a000 1", pix_valid, pix_data, pix_sof); end
    endtask

    task automatic test_preempt();
        int cnt = 4;
        int fetch_idx = 4;
        int pop_idx = 0;
        int wr_n = 0;
        bit exp_vf;
        logic [14:0] exp_a;
        logic [15:0] exp_d;
        pix_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = 15'(15'h0100 + wr_n); cpu_wdata = 16'(16'h5000 + wr_n);
            #1;
            exp_vf = (cnt < 4) && (cnt < 1);
            exp_a  = exp_vf ? 15'(15'h4000 + fetch_idx) : 15'(15'h0100 + wr_n);
            checks++; if (cpu_ack !== !exp_vf) begin errors++; $display("FAIL pre_ack cyc %0d: got %b want %b", c, cpu_ack, !exp_vf); end
            checks++; if (mem_address !== exp_a) begin errors++; $display("FAIL pre_addr cyc %0d: got %h want %h", c, mem_address, exp_a); end
            checks++; if (mem_load !== !exp_vf) begin errors++; $display("FAIL pre_load cyc %0d: got %b want %b", c, mem_load, !exp_vf); end
            if (cnt > 0) begin
                exp_d = 16'(16'hA000 + pop_idx);
                checks++; if (pix_valid !== 1'b1 || pix_data !== exp_d)
                    begin errors++; $display("FAIL pre_head cyc %0d: got v=%b d=%h want 1 %h", c, pix_valid, pix_data, exp_d); end
            end
            if (cnt > 0) begin cnt--; pop_idx++; end
            if (exp_vf) begin cnt++; fetch_idx++; end
            else wr_n++;
            step();
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        for (int j = 0; j < wr_n; j++) begin
            exp_d = 16'(16'h5000 + j);
            checks++; if (ram[15'h0100 + j] !== exp_d) begin errors++; $display("FAIL pre_ram %0d: got %h want %h", j, ram[15'h0100 + j], exp_d); end
        end
        checks++; if (ram[15'(15'h0100 + wr_n)] !== 16'h0000)
            begin errors++; $display("FAIL pre_extra: got %h want 0000", ram[15'(15'h0100 + wr_n)]); end
    endtask

    task automatic test_cpu_read();
        vid_enable = 1'b0; pix_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010; cpu_wdata = 16'hFFFF;
        #1;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h want 1234", cpu_rdata); end
        checks++; if (mem_load !== 1'b0 || mem_address !== 15'h0010)
            begin errors++; $display("FAIL rd_port: got load=%b a=%h want 0 0010", mem_load, mem_address); end
        step();
        cpu_we = 1'b1; cpu_addr = 15'h6000; cpu_wdata = 16'hDEAD;
        #1;
        checks++; if (pix_valid !== 1'b0 || pix_data !== 16'h0000)
            begin errors++; $display("FAIL rd_flush: got v=%b d=%h want 0 0000", pix_valid, pix_data); end
        checks++; if (mem_address !== 15'h6000 || mem_load !== 1'b1 || mem_in !== 16'hDEAD || cpu_ack !== 1'b1)
            begin errors++; $display("FAIL kbd_pass: got a=%h l=%b d=%h k=%b want 6000 1 dead 1", mem_address, mem_load, mem_in, cpu_ack); end
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_wrap();
        logic [14:0] exp_a;
        vid_enable = 1'b1; pix_ready = 1'b1;
        for (int i = 0; i < 8194; i++) begin
            #1;
            if (i <= 1 || i >= 8190) begin
                exp_a = 15'(15'h4000 + (i % 8192));
                checks++; if (mem_address !== exp_a) begin errors++; $display("FAIL wrap_addr cyc %0d: got %h want %h", i, mem_address, exp_a); end
            end
            if (i == 0) begin
                checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL wrap_v0: got %b want 0", pix_valid); end
            end
            if (i == 1 || i == 8193) begin
                checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000 || pix_sof !== 1'b1)
                    begin errors++; $display("FAIL wrap_sof cyc %0d: got v=%b d=%h s=%b want 1 a000 1", i, pix_valid, pix_data, pix_sof); end
            end
            if (i == 8192) begin
                checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hBFFF || pix_sof !== 1'b0)
                    begin errors++; $display("FAIL wrap_last: got v=%b d=%h s=%b want 1 bfff 0", pix_valid, pix_data, pix_sof); end
            end
            step();
        end
    endtask

    task automatic test_reset_burst();
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h01FE; cpu_wdata = 16'h1111;
        #1;
        checks++; if (cpu_ack !== 1'b1 || mem_address !== 15'h01FE || mem_load !== 1'b1)
            begin errors++; $display("FAIL rb_w0: got k=%b a=%h l=%b want 1 01fe 1", cpu_ack, mem_address, mem_load); end
        step();
        cpu_addr = 15'h01FF; cpu_wdata = 16'h2222;
        #1;
        checks++; if (cpu_ack !== 1'b1 || mem_address !== 15'h01FF)
            begin errors++; $display("FAIL rb_w1: got k=%b a=%h want 1 01ff", cpu_ack, mem_address); end
        step();
        cpu_addr = 15'h0200; cpu_wdata = 16'h3333; reset = 1'b1;
        #1;
        checks++; if (cpu_ack !== 1'b0 || mem_load !== 1'b0)
            begin errors++; $display("FAIL rb_rst: got k=%b l=%b want 0 0", cpu_ack, mem_load); end
        checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL rb_prevalid: got %b want 1", pix_valid); end
        step();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rb_valid: got %b want 0", pix_valid); end
        checks++; if (ram[15'h0200] !== 16'h7777) begin errors++; $display("FAIL rb_ram200: got %h want 7777", ram[15'h0200]); end
        checks++; if (ram[15'h01FE] !== 16'h1111 || ram[15'h01FF] !== 16'h2222)
            begin errors++; $display("FAIL rb_ramprev: got %h %h want 1111 2222", ram[15'h01FE], ram[15'h01FF]); end
        step();
    endtask

    task automatic test_flush();
        step();
        step();
        vid_enable = 1'b0;
        #1;
        checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000 || pix_sof !== 1'b1)
            begin errors++; $display("FAIL fl_head: got v=%b d=%h s=%b want 1 a000 1", pix_valid, pix_data, pix_sof); end
        checks++; if (mem_address !== 15'h0000) begin errors++; $display("FAIL fl_idle: got %h want 0000", mem_address); end
        step();
        vid_enable = 1'b1;
        #1;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", pix_valid); end
        checks++; if (mem_address !== 15'h4000) begin errors++; $display("FAIL fl_addr: got %h want 4000", mem_address); end
        step();
        #1;
        checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000 || pix_sof !== 1'b1)
            begin errors++; $display("FAIL fl_first: got v=%b d=%h s=%b want 1 a000 1", pix_valid, pix_data, pix_sof); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_preempt();
        test_cpu_read();
        test_wrap();
        test_reset_burst();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
